// File: rtl/serial_cla_if.sv
// Request/result bundle for the serial carry-lookahead sequencer.
// The requester drives start and the operands; the sequencer returns status and the result.
interface serial_cla_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_cla_sequencer.sv
// Multi-cycle adder: streams 2-bit slices, LSB first, through a 2-bit carry-lookahead cell.
// The carry is registered between slices, so one narrow cell serves any even operand width.
module serial_cla_sequencer #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   serial_cla_if.slave bus
);
   localparam int N    = WIDTH / 2;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDXW-1:0]  IDX_ZERO   = IDXW'(0);
   localparam logic [IDXW-1:0]  IDX_ONE    = IDXW'(1);
   localparam logic [IDXW-1:0]  IDX_LAST   = IDXW'(N - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(2'b11);

   // Returns {c2, s1, s0} for one 2-bit lookahead slice.
   function automatic logic [2:0] cla2(input logic [1:0] x, input logic [1:0] y, input logic c0);
      logic [1:0] g;
      logic [1:0] p;
      logic       c1;
      logic       c2;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & c1);
      return {c2, p[1] ^ c1, p[0] ^ c0};
   endfunction

   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  idx_q,   idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic [$clog2(WIDTH+1)-1:0] shamt_s;
   logic [2:0]                 slice_s;

   // Next-state logic: operand capture, slice processing and the handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      shamt_s = {$clog2(WIDTH+1){1'b0}};
      shamt_s[IDXW:0] = {idx_q, 1'b0};
      slice_s = cla2(2'(a_q >> shamt_s), 2'(b_q >> shamt_s), carry_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = IDX_ZERO;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d   = (sum_q & ~(SLICE_MASK << shamt_s)) | (WIDTH'(slice_s[1:0]) << shamt_s);
            carry_d = slice_s[2];
            if (idx_q == IDX_LAST) begin
               cout_d  = slice_s[2];
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDX_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status is derived from the next state so busy/done can be driven straight from flops.
      busy_d = (state_d == ST_RUN) || (state_d == ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_ZERO;
         carry_q <= 1'b0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_cla_sequencer.sv
// Directed bench for serial_cla_sequencer at WIDTH=8, WIDTH=2 (exhaustive) and WIDTH=16 (random).
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_serial_cla_sequencer;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   serial_cla_if #(.WIDTH(8))  bus8  ();
   serial_cla_if #(.WIDTH(2))  bus2  ();
   serial_cla_if #(.WIDTH(16)) bus16 ();

   serial_cla_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_cla_sequencer #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   serial_cla_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the sequencer is back in IDLE,
   // so a following call issues at the minimum interval.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic hold, input logic [8:0] exp);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = c;
      for (int e = 0; e <= 4; e++) begin
         @(negedge clk);
         if (e == 0) begin
            if (hold) begin
               bus8.a = 8'hFF;
               bus8.b = 8'hFF;
            end else begin
               bus8.start = 1'b0;
            end
         end
         chk("busy8", 64'(bus8.busy), 64'(1'b1));
         chk("done8", 64'(bus8.done), 64'(e == 4));
      end
      chk("result8", 64'({bus8.cout, bus8.sum}), 64'(exp));
      @(negedge clk);
      chk("idle_busy8", 64'(bus8.busy), 64'(1'b0));
      chk("idle_done8", 64'(bus8.done), 64'(1'b0));
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
      logic [2:0] exp;
      exp        = 3'(a) + 3'(b) + 3'(c);
      bus2.start = 1'b1;
      bus2.a     = a;
      bus2.b     = b;
      bus2.cin   = c;
      for (int e = 0; e <= 1; e++) begin
         @(negedge clk);
         bus2.start = 1'b0;
         chk("busy2", 64'(bus2.busy), 64'(1'b1));
         chk("done2", 64'(bus2.done), 64'(e == 1));
      end
      chk("result2", 64'({bus2.cout, bus2.sum}), 64'(exp));
      @(negedge clk);
      chk("idle_done2", 64'(bus2.done), 64'(1'b0));
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] exp;
      exp         = 17'(a) + 17'(b) + 17'(c);
      bus16.start = 1'b1;
      bus16.a     = a;
      bus16.b     = b;
      bus16.cin   = c;
      for (int e = 0; e <= 8; e++) begin
         @(negedge clk);
         bus16.start = 1'b0;
         chk("busy16", 64'(bus16.busy), 64'(1'b1));
         chk("done16", 64'(bus16.done), 64'(e == 8));
      end
      chk("result16", 64'({bus16.cout, bus16.sum}), 64'(exp));
      @(negedge clk);
      chk("idle_busy16", 64'(bus16.busy), 64'(1'b0));
      chk("idle_done16", 64'(bus16.done), 64'(1'b0));
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus8.start  = 1'b0; bus8.a  = 8'h00;  bus8.b  = 8'h00;  bus8.cin  = 1'b0;
      bus2.start  = 1'b0; bus2.a  = 2'h0;   bus2.b  = 2'h0;   bus2.cin  = 1'b0;
      bus16.start = 1'b0; bus16.a = 16'h0;  bus16.b = 16'h0;  bus16.cin = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus8.busy), 64'(1'b0));
      chk("rst_done", 64'(bus8.done), 64'(1'b0));
      chk("rst_sum",  64'(bus8.sum),  64'(8'h00));
      chk("rst_cout", 64'(bus8.cout), 64'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add, full carry ripple, carry-in ripple.
      run8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096);
      run8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
      run8(8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);

      // start held high with new operands while busy; re-accepted on first IDLE cycle.
      run8(8'h12, 8'h34, 1'b0, 1'b1, 9'h046);
      run8(8'hFF, 8'hFF, 1'b0, 1'b0, 9'h1FE);

      // Asynchronous reset two cycles into an operation.
      bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bus8.busy), 64'(1'b0));
      chk("abort_done", 64'(bus8.done), 64'(1'b0));
      chk("abort_sum",  64'(bus8.sum),  64'(8'h00));
      chk("abort_cout", 64'(bus8.cout), 64'(1'b0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_done", 64'(bus8.done), 64'(1'b0));
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_done_after", 64'(bus8.done), 64'(1'b0));
      end
      run8(8'hAA, 8'h55, 1'b0, 1'b0, 9'h0FF);

      // WIDTH=2: every operand/carry combination, back-to-back.
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 2; c++) begin
               run2(2'(a), 2'(b), 1'(c));
            end
         end
      end

      // WIDTH=16: random operands at the minimum issue interval.
      for (int i = 0; i < 1000; i++) begin
         run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      bus16.start = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
